// File: rtl/add_sub_cla_pipe.sv
// rtl/add_sub_cla_pipe.sv - pipelined chunked-CLA two's-complement adder/subtractor
// One carry chunk per register stage; valid/ready with a global stall, optional saturation, sticky overflow.
module add_sub_cla_pipe #(
  parameter int WIDTH    = 16,
  parameter int STAGES   = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             invalid,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  // Lookahead carries expanded as sum-of-products over the chunk.
  function automatic logic [CW:0] cla_chunk(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic          ci);
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW:0]   c;
    logic          acc;
    logic          pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CW; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & ci);
    end
    return {c[CW], p ^ c[CW-1:0]};
  endfunction

  // Per-stage word: operand A with the chunks below the stage already replaced by sum bits.
  logic [WIDTH-1:0] word_q [STAGES];
  logic [WIDTH-1:0] word_d [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] b_d    [STAGES];
  logic             c_q    [STAGES];
  logic             c_d    [STAGES];
  logic             v_q    [STAGES];
  logic             v_d    [STAGES];

  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             invalid_q, invalid_d;
  logic             out_valid_q, out_valid_d;
  logic             sticky_q, sticky_d;

  logic             adv;
  logic [CW:0]      chunk;
  logic [CW:0]      top;
  logic [WIDTH-1:0] raw;
  logic             ovf;

  assign adv = !out_valid_q || out_ready;

  always_comb begin
    chunk     = '0;
    word_d[0] = in1;
    b_d[0]    = in2 ^ {WIDTH{sub}};
    c_d[0]    = cin ^ sub;
    v_d[0]    = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      chunk     = cla_chunk(word_q[k-1][(k-1)*CW +: CW], b_q[k-1][(k-1)*CW +: CW], c_q[k-1]);
      word_d[k] = word_q[k-1];
      word_d[k][(k-1)*CW +: CW] = chunk[CW-1:0];
      b_d[k]    = b_q[k-1];
      c_d[k]    = chunk[CW];
      v_d[k]    = v_q[k-1];
    end

    top = cla_chunk(word_q[L][L*CW +: CW], b_q[L][L*CW +: CW], c_q[L]);
    raw = word_q[L];
    raw[L*CW +: CW] = top[CW-1:0];
    ovf = (word_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (raw[WIDTH-1] != word_q[L][WIDTH-1]);

    out_valid_d = v_q[L];
    cout_d      = top[CW];
    invalid_d   = ovf;
    out_d       = raw;
    if (SATURATE != 0 && ovf) begin
      out_d = word_q[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    sticky_d = sticky_q;
    if (out_valid_q && out_ready && invalid_q) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        word_q[k] <= '0;
        b_q[k]    <= '0;
        c_q[k]    <= 1'b0;
        v_q[k]    <= 1'b0;
      end
      out_q       <= '0;
      cout_q      <= 1'b0;
      invalid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      if (adv) begin
        for (int k = 0; k < STAGES; k++) begin
          word_q[k] <= word_d[k];
          b_q[k]    <= b_d[k];
          c_q[k]    <= c_d[k];
          v_q[k]    <= v_d[k];
        end
        out_q       <= out_d;
        cout_q      <= cout_d;
        invalid_q   <= invalid_d;
        out_valid_q <= out_valid_d;
      end
      sticky_q <= sticky_d;
    end
  end

  assign in_ready   = adv;
  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign cout       = cout_q;
  assign invalid    = invalid_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_add_sub_cla_pipe.sv
// tb/tb_add_sub_cla_pipe.sv - directed bench for add_sub_cla_pipe, wrap and saturate instances
module tb_add_sub_cla_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, sub, cin, out_ready, clr_sticky;
  logic [W-1:0] in1, in2;
  logic         in_ready0, out_valid0, cout0, inv0, st0;
  logic         in_ready1, out_valid1, cout1, inv1, st1;
  logic [W-1:0] out0, out1;

  add_sub_cla_pipe #(.WIDTH(W), .STAGES(4), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .sub(sub), .cin(cin),
    .in1(in1), .in2(in2), .out_valid(out_valid0), .out_ready(out_ready), .out(out0),
    .cout(cout0), .invalid(inv0), .ovf_sticky(st0), .clr_sticky(clr_sticky));

  add_sub_cla_pipe #(.WIDTH(W), .STAGES(4), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .sub(sub), .cin(cin),
    .in1(in1), .in2(in2), .out_valid(out_valid1), .out_ready(out_ready), .out(out1),
    .cout(cout1), .invalid(inv1), .ovf_sticky(st1), .clr_sticky(clr_sticky));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] e_wrap;
    logic [W-1:0] e_sat;
    logic         e_cout;
    logic         e_inv;
  } vec_t;

  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;
  logic sticky_m = 1'b0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic run_one(input vec_t v, input logic clr_at_dlv, input int idx);
    in1 = v.a; in2 = v.b; sub = v.sub; cin = v.cin;
    in_valid = 1'b1; out_ready = 1'b1; clr_sticky = 1'b0;
    #1 chk("in_ready", idx, in_ready0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = W'($urandom); in2 = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    chk("early_valid", idx, out_valid0, 0);
    @(posedge clk); #1;
    chk("valid_wrap", idx, out_valid0, 1);
    chk("valid_sat", idx, out_valid1, 1);
    chk("out_wrap", idx, out0, v.e_wrap);
    chk("out_sat", idx, out1, v.e_sat);
    chk("cout_wrap", idx, cout0, v.e_cout);
    chk("cout_sat", idx, cout1, v.e_cout);
    chk("inv_wrap", idx, inv0, v.e_inv);
    chk("inv_sat", idx, inv1, v.e_inv);
    clr_sticky = clr_at_dlv;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    if (v.e_inv) sticky_m = 1'b1;
    else if (clr_at_dlv) sticky_m = 1'b0;
    chk("drained", idx, out_valid0, 0);
    chk("sticky_wrap", idx, st0, sticky_m);
    chk("sticky_sat", idx, st1, sticky_m);
  endtask

  initial begin
    int   sent, got, stall_left;
    bit   first_seen;

    vecs[0] = '{16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 16'h0005, 1'b0, 1'b0};
    vecs[1] = '{16'h0002, 16'h0003, 1'b0, 1'b1, 16'h0006, 16'h0006, 1'b0, 1'b0};
    vecs[2] = '{16'h0006, 16'h0003, 1'b1, 1'b0, 16'h0003, 16'h0003, 1'b1, 1'b0};
    vecs[3] = '{16'h0006, 16'h0003, 1'b1, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
    vecs[8] = '{16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 16'h2143, 1'b0, 1'b0};
    vecs[9] = '{16'h0FFF, 16'h0001, 1'b0, 1'b1, 16'h1001, 16'h1001, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    clr_sticky = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 0, out_valid0, 0);
    chk("rst_out", 0, out0, 0);
    chk("rst_cout", 0, cout0, 0);
    chk("rst_inv", 0, inv0, 0);
    chk("rst_sticky", 0, st0, 0);
    chk("rst_in_ready", 0, in_ready0, 1);
    chk("rst_valid_sat", 0, out_valid1, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_one(vecs[i], 1'b0, i);

    // Reset with beats in flight: first result just presented, four more behind it.
    for (int i = 0; i < 5; i++) begin
      in1 = 16'h7FFF; in2 = 16'h0001; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 0, out_valid0, 1);
    chk("pre_rst_sticky", 0, st0, sticky_m);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 0, out_valid0, 0);
    chk("mid_rst_valid_sat", 0, out_valid1, 0);
    chk("mid_rst_sticky", 0, st0, 0);
    chk("mid_rst_sticky_sat", 0, st1, 0);
    chk("mid_rst_in_ready", 0, in_ready0, 1);
    sticky_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_one(vecs[0], 1'b0, 100);

    // Sticky: set, plain clear, then set and clear on the same edge.
    run_one(vecs[4], 1'b0, 101);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    sticky_m = 1'b0;
    chk("clr_sticky", 0, st0, 0);
    chk("clr_sticky_sat", 0, st1, 0);
    run_one(vecs[7], 1'b1, 102);
    run_one(vecs[0], 1'b1, 103);

    // Stall: 8 back-to-back beats, out_ready low for 3 cycles at the first result.
    sent = 0; got = 0; stall_left = 0; first_seen = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (out_valid0 && !first_seen) begin
        first_seen = 1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent < 8);
      in1 = W'(sent); in2 = 16'h0001; sub = 1'b0; cin = 1'b0;
      #1;
      if (stall_left > 0) begin
        chk("stall_in_ready", stall_left, in_ready0, 0);
        chk("stall_valid", stall_left, out_valid0, 1);
        chk("stall_hold", stall_left, out0, 16'h0001);
        stall_left--;
      end
      if (out_valid0 && out_ready) begin
        chk("stall_order", got, out0, got + 1);
        got++;
      end
      if (in_valid && in_ready0) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_count", 0, got, 8);
    chk("stall_sent", 0, sent, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
